// File: rtl/secp256k1_pkg.sv
// Shared constants for the secp256k1 field datapath: field width, prime and
// the add/sub unit opcode encoding.
package secp256k1_pkg;

    localparam int FIELD_W = 256;

    localparam logic [FIELD_W-1:0] SECP256K1_P =
        256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_NEG = 2'd2;
    localparam logic [1:0] OP_DBL = 2'd3;

    // Sub and neg produce a borrow-style raw value; add and double an overflow-style one.
    function automatic logic is_sub_like(input logic [1:0] op);
        return (op == OP_SUB) || (op == OP_NEG);
    endfunction

endpackage

// File: rtl/secp256k1_mod_correct.sv
// Single-step modular correction of a (W+1)-bit raw sum or difference back
// into [0, modulus) for in-range operands.
module secp256k1_mod_correct
    import secp256k1_pkg::*;
#(
    parameter int W = FIELD_W
) (
    input  logic [W:0]   raw,
    input  logic         sub_like,
    input  logic [W-1:0] modulus,
    output logic [W-1:0] result
);

    always_comb begin
        result = raw[W-1:0];
        if (sub_like) begin
            // A borrow means the difference wrapped; adding the modulus back
            // modulo 2^W restores the canonical value.
            if (raw[W]) begin
                result = raw[W-1:0] + modulus;
            end
        end else if (raw >= {1'b0, modulus}) begin
            // Low W bits of (raw - modulus) equal this truncated difference.
            result = raw[W-1:0] - modulus;
        end
    end

endmodule

// File: rtl/secp256k1_addsub_mod_pipe.sv
// Two-stage pipelined modular add/sub/neg/double with valid/ready flow
// control and a pass-through tag.
module secp256k1_addsub_mod_pipe
    import secp256k1_pkg::*;
#(
    parameter int             W       = FIELD_W,
    parameter logic [W-1:0]   MODULUS = W'(SECP256K1_P),
    parameter int             TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    logic [W:0]       raw_next;
    logic             err_next;
    logic [W-1:0]     corrected;
    logic             adv;

    logic             s1_valid_reg;
    logic [W:0]       s1_raw_reg;
    logic             s1_sub_reg;
    logic [TAG_W-1:0] s1_tag_reg;
    logic             s1_err_reg;

    logic             s2_valid_reg;
    logic [W-1:0]     s2_result_reg;
    logic [TAG_W-1:0] s2_tag_reg;
    logic             s2_err_reg;

    assign adv      = !s2_valid_reg || out_ready;
    assign in_ready = adv || !s1_valid_reg;

    // Raw arithmetic is one bit wider so the top bit carries overflow or borrow.
    always_comb begin
        raw_next = '0;
        err_next = 1'b0;
        unique case (in_op)
            OP_ADD: begin
                raw_next = {1'b0, in_a} + {1'b0, in_b};
                err_next = (in_a >= MODULUS) || (in_b >= MODULUS);
            end
            OP_SUB: begin
                raw_next = {1'b0, in_a} - {1'b0, in_b};
                err_next = (in_a >= MODULUS) || (in_b >= MODULUS);
            end
            OP_NEG: begin
                raw_next = '0 - {1'b0, in_b};
                err_next = (in_b >= MODULUS);
            end
            OP_DBL: begin
                raw_next = {1'b0, in_a} + {1'b0, in_a};
                err_next = (in_a >= MODULUS);
            end
        endcase
    end

    secp256k1_mod_correct #(
        .W (W)
    ) u_mod_correct (
        .raw      (s1_raw_reg),
        .sub_like (s1_sub_reg),
        .modulus  (MODULUS),
        .result   (corrected)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg  <= 1'b0;
            s1_raw_reg    <= '0;
            s1_sub_reg    <= 1'b0;
            s1_tag_reg    <= '0;
            s1_err_reg    <= 1'b0;
            s2_valid_reg  <= 1'b0;
            s2_result_reg <= '0;
            s2_tag_reg    <= '0;
            s2_err_reg    <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid_reg <= in_valid;
                if (in_valid) begin
                    s1_raw_reg <= raw_next;
                    s1_sub_reg <= is_sub_like(in_op);
                    s1_tag_reg <= in_tag;
                    s1_err_reg <= err_next;
                end
            end
            // Output data only changes on a real transfer, so it holds under stall.
            if (adv) begin
                s2_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    s2_result_reg <= corrected;
                    s2_tag_reg    <= s1_tag_reg;
                    s2_err_reg    <= s1_err_reg;
                end
            end
        end
    end

    assign out_valid  = s2_valid_reg;
    assign out_result = s2_result_reg;
    assign out_tag    = s2_tag_reg;
    assign out_err    = s2_err_reg;

endmodule

// File: tb/tb_secp256k1_addsub_mod_pipe.sv
// Self-checking bench: directed vector table, random streaming, backpressure
// and reset-in-flight sequences against a modular-arithmetic reference.
module tb_secp256k1_addsub_mod_pipe;
    import secp256k1_pkg::*;

    localparam int W     = 256;
    localparam int TAG_W = 4;
    localparam logic [W-1:0] P = SECP256K1_P;

    typedef struct {
        logic [1:0]       op;
        logic [W-1:0]     a;
        logic [W-1:0]     b;
        logic [TAG_W-1:0] tag;
        logic [W-1:0]     res;
        logic             err;
    } vec_t;

    typedef struct {
        logic [W-1:0]     res;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_op = 2'd0;
    logic [W-1:0]     in_a = '0;
    logic [W-1:0]     in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W-1:0]     out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    always #5 clk = ~clk;

    secp256k1_addsub_mod_pipe #(
        .W       (W),
        .MODULUS (P),
        .TAG_W   (TAG_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_err    (out_err)
    );

    int               n_checks = 0;
    int               n_errors = 0;
    int               cyc = 0;
    exp_t             exp_q[$];
    int               out_cyc_q[$];
    logic             prev_stall = 1'b0;
    logic [W-1:0]     prev_res = '0;
    logic [TAG_W-1:0] prev_tag = '0;
    logic             prev_err = 1'b0;
    vec_t             tbl[12];

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, expv);
        end
    endtask

    // Reference: plain modular arithmetic on wide integers.
    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [TAG_W-1:0] tag);
        logic [W+1:0] aa;
        logic [W+1:0] bb;
        logic [W+1:0] pp;
        exp_t e;
        aa = {2'b00, a};
        bb = {2'b00, b};
        pp = {2'b00, P};
        e.tag = tag;
        e.res = '0;
        e.err = 1'b0;
        case (op)
            OP_ADD: begin e.res = W'((aa + bb) % pp);      e.err = (a >= P) || (b >= P); end
            OP_SUB: begin e.res = W'((aa + pp - bb) % pp); e.err = (a >= P) || (b >= P); end
            OP_NEG: begin e.res = W'((pp - bb) % pp);      e.err = (b >= P); end
            default: begin e.res = W'((aa + aa) % pp);     e.err = (a >= P); end
        endcase
        return e;
    endfunction

    function automatic logic [W-1:0] rand_fe();
        logic [W-1:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = P - 1;
            2:       v = W'(1);
            default: v = v % P;
        endcase
        return v;
    endfunction

    task automatic next_cyc();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Observe one cycle at the falling edge: flow control, hold, scoreboard.
    task automatic sample();
        exp_t e;
        logic exp_ready;
        @(negedge clk);
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
            chk("reset_out_valid", W'(out_valid), W'(0));
        end else begin
            exp_ready = (exp_q.size() < 2) || out_ready;
            chk("in_ready", W'(in_ready), W'(exp_ready));
            if (prev_stall) begin
                chk("hold_valid", W'(out_valid), W'(1));
                chk("hold_result", out_result, prev_res);
                chk("hold_tag", W'(out_tag), W'(prev_tag));
                chk("hold_err", W'(out_err), W'(prev_err));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_output: got tag %0d result %h, expected no output",
                             out_tag, out_result);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn cyc=%0d tag=%0d err=%0b result=%h", cyc, out_tag, out_err, out_result);
                    chk("sb_tag", W'(out_tag), W'(e.tag));
                    chk("sb_err", W'(out_err), W'(e.err));
                    if (!e.err) chk("sb_result", out_result, e.res);
                    out_cyc_q.push_back(cyc);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = out_result;
            prev_tag   = out_tag;
            prev_err   = out_err;
            if (in_valid && in_ready) exp_q.push_back(model(in_op, in_a, in_b, in_tag));
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        in_valid = 1'b1;
        in_op    = v.op;
        in_a     = v.a;
        in_b     = v.b;
        in_tag   = v.tag;
        sample();
        chk({name, "_accept"}, W'(in_ready), W'(1));
        next_cyc();
        in_valid = 1'b0;
        sample();
        chk({name, "_lat_early"}, W'(out_valid), W'(0));
        next_cyc();
        sample();
        chk({name, "_lat_valid"}, W'(out_valid), W'(1));
        chk({name, "_result"}, out_result, v.res);
        chk({name, "_tag"}, W'(out_tag), W'(v.tag));
        chk({name, "_err"}, W'(out_err), W'(v.err));
        next_cyc();
    endtask

    initial begin
        int base;
        int c0;
        int sent;
        int blocked;
        logic need_new;
        logic acc;

        tbl[0]  = '{OP_ADD, P - 1,      W'(1),   4'd3,  W'(0),  1'b0};
        tbl[1]  = '{OP_ADD, W'(5),      W'(7),   4'd1,  W'(12), 1'b0};
        tbl[2]  = '{OP_SUB, W'(0),      W'(1),   4'd2,  P - 1,  1'b0};
        tbl[3]  = '{OP_SUB, W'(5),      W'(3),   4'd4,  W'(2),  1'b0};
        tbl[4]  = '{OP_SUB, P - 1,      P - 1,   4'd5,  W'(0),  1'b0};
        tbl[5]  = '{OP_NEG, W'(123),    W'(0),   4'd6,  W'(0),  1'b0};
        tbl[6]  = '{OP_NEG, W'(0),      W'(1),   4'd7,  P - 1,  1'b0};
        tbl[7]  = '{OP_DBL, P - 1,      W'(0),   4'd8,  P - 2,  1'b0};
        tbl[8]  = '{OP_DBL, W'(2),      W'(9),   4'd9,  W'(4),  1'b0};
        tbl[9]  = '{OP_ADD, P,          W'(0),   4'd10, W'(0),  1'b1};
        tbl[10] = '{OP_NEG, P,          W'(1),   4'd11, P - 1,  1'b0};
        tbl[11] = '{OP_DBL, W'(2),      P,       4'd12, W'(4),  1'b0};

        // Reset state
        out_ready = 1'b1;
        sample();
        chk("reset_result", out_result, W'(0));
        chk("reset_tag", W'(out_tag), W'(0));
        chk("reset_err", W'(out_err), W'(0));
        #2 rst_n = 1'b1;
        next_cyc();

        for (int i = 0; i < 12; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Streaming: 20 back-to-back random ops
        base = out_cyc_q.size();
        c0 = cyc;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_op    = 2'($urandom_range(0, 3));
            in_a     = rand_fe();
            in_b     = rand_fe();
            in_tag   = TAG_W'(i);
            sample();
            next_cyc();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sample();
            next_cyc();
        end
        chk("stream_count", W'(out_cyc_q.size() - base), W'(20));
        if (out_cyc_q.size() - base == 20) begin
            chk("stream_latency", W'(out_cyc_q[base] - c0), W'(2));
            chk("stream_no_gaps", W'(out_cyc_q[base + 19] - out_cyc_q[base]), W'(19));
        end

        // Backpressure: out_ready low for 5 cycles mid-stream
        base = out_cyc_q.size();
        sent = 0;
        blocked = 0;
        need_new = 1'b1;
        for (int j = 0; j < 60 && sent < 16; j++) begin
            if (need_new) begin
                in_op  = 2'($urandom_range(0, 3));
                in_a   = rand_fe();
                in_b   = rand_fe();
                in_tag = TAG_W'(sent);
            end
            in_valid  = 1'b1;
            out_ready = !(j >= 4 && j < 9);
            sample();
            acc = in_ready;
            if (!out_ready && !in_ready) blocked++;
            next_cyc();
            if (acc) sent++;
            need_new = acc;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sample();
            next_cyc();
        end
        chk("bp_sent", W'(sent), W'(16));
        chk("bp_count", W'(out_cyc_q.size() - base), W'(16));
        chk("bp_ready_drop", W'(blocked > 0), W'(1));

        // Reset with two ops in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = OP_ADD;
        in_a      = W'(1);
        in_b      = W'(2);
        in_tag    = 4'd13;
        sample();
        next_cyc();
        in_tag    = 4'd14;
        sample();
        next_cyc();
        in_valid  = 1'b0;
        sample();
        chk("rst_pre_valid", W'(out_valid), W'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_valid", W'(out_valid), W'(0));
        chk("rst_async_result", out_result, W'(0));
        chk("rst_async_tag", W'(out_tag), W'(0));
        next_cyc();
        sample();
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            next_cyc();
            sample();
            chk("rst_no_stale", W'(out_valid), W'(0));
        end
        next_cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
